// File: rtl/pc_unit_if.sv
// Bus between the IF-stage program counter and the pipeline control that steers it.
// The master side supplies next-PC controls and targets; the slave side returns the PC state.
interface pc_unit_if #(
    parameter int AW = 32
) ();
    localparam int PW = AW - 2;

    logic          pc_wr;
    logic [1:0]    npc_sel;
    logic [PW-1:0] br_target;
    logic [PW-1:0] j_target;
    logic [PW-1:0] jr_target;
    logic          call;
    logic          ret_pred;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic          exc_req;
    logic [PW-1:0] exc_epc;
    logic          eret;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_plus1;
    logic [PW-1:0] epc;
    logic          exl;
    logic          ras_empty;

    modport master (
        output pc_wr, npc_sel, br_target, j_target, jr_target, call, ret_pred,
               redirect, redirect_pc, exc_req, exc_epc, eret,
        input  pc, pc_plus1, epc, exl, ras_empty
    );

    modport slave (
        input  pc_wr, npc_sel, br_target, j_target, jr_target, call, ret_pred,
               redirect, redirect_pc, exc_req, exc_epc, eret,
        output pc, pc_plus1, epc, exl, ras_empty
    );
endinterface

// File: rtl/pc_unit.sv
// IF-stage program counter: word-addressed PC with reset vector, stall, prioritised
// next-PC selection, single-level exception entry/return (EPC/EXL) and a circular
// return-address stack that predicts jr $ra targets.
module pc_unit #(
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   RESET_VEC = 32'h0000_3000,
    parameter logic [AW-1:0]   EXC_VEC   = 32'h0000_4180,
    parameter int              RAS_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);
    localparam int PW   = AW - 2;
    localparam int PTRW = $clog2(RAS_DEPTH);
    localparam int CW   = PTRW + 1;

    localparam logic [PW-1:0]   PC_ONE   = PW'(1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]   CNT_FULL = CW'(RAS_DEPTH);

    logic [PW-1:0]   pc_q,  pc_d;
    logic [PW-1:0]   epc_q, epc_d;
    logic            exl_q, exl_d;
    logic [PTRW-1:0] ras_ptr_q, ras_ptr_d;
    logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
    logic            ras_empty_q;
    logic [PW-1:0]   ras_mem_q [RAS_DEPTH];

    logic [PW-1:0]   pc_plus1_s;
    logic [PW-1:0]   ras_top_s;
    logic            push_s;
    logic            pop_s;
    logic            ras_we_s;
    logic [PTRW-1:0] ras_wa_s;

    assign pc_plus1_s = pc_q + PC_ONE;
    assign ras_top_s  = ras_mem_q[ras_ptr_q];

    // Only the normal advance path (no exception/eret/redirect) may touch the RAS.
    assign push_s = bus.call;
    assign pop_s  = (bus.npc_sel == 2'b11) && bus.ret_pred && !ras_empty_q;

    // Next-state selection: exception > eret > redirect > normal advance > hold.
    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        exl_d     = exl_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we_s  = 1'b0;
        ras_wa_s  = ras_ptr_q;
        if (bus.exc_req && !exl_q) begin
            pc_d  = EXC_VEC[AW-1:2];
            epc_d = bus.exc_epc;
            exl_d = 1'b1;
        end else if (bus.eret && exl_q) begin
            pc_d  = epc_q;
            exl_d = 1'b0;
        end else if (bus.redirect) begin
            pc_d = bus.redirect_pc;
        end else if (bus.pc_wr) begin
            case (bus.npc_sel)
                2'b00:   pc_d = pc_plus1_s;
                2'b01:   pc_d = bus.br_target;
                2'b10:   pc_d = bus.j_target;
                2'b11:   pc_d = pop_s ? ras_top_s : bus.jr_target;
                default: pc_d = pc_plus1_s;
            endcase
            if (push_s && pop_s) begin
                // Return and call together: the popped slot is reused for the new link.
                ras_we_s = 1'b1;
                ras_wa_s = ras_ptr_q;
            end else if (push_s) begin
                // Full stack wraps and silently overwrites the oldest entry.
                ras_we_s  = 1'b1;
                ras_wa_s  = ras_ptr_q + PTR_ONE;
                ras_ptr_d = ras_ptr_q + PTR_ONE;
                ras_cnt_d = (ras_cnt_q == CNT_FULL) ? ras_cnt_q : ras_cnt_q + CNT_ONE;
            end else if (pop_s) begin
                ras_ptr_d = ras_ptr_q - PTR_ONE;
                ras_cnt_d = ras_cnt_q - CNT_ONE;
            end else begin
                ras_we_s = 1'b0;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // PC, exception state and RAS bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_VEC[AW-1:2];
            epc_q       <= {PW{1'b0}};
            exl_q       <= 1'b0;
            ras_ptr_q   <= {PTRW{1'b0}};
            ras_cnt_q   <= CNT_ZERO;
            ras_empty_q <= 1'b1;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            exl_q       <= exl_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_cnt_q   <= ras_cnt_d;
            ras_empty_q <= (ras_cnt_d == CNT_ZERO);
        end
    end

    // RAS storage; contents are don't-care after reset since count gates every read.
    always_ff @(posedge clk) begin
        if (ras_we_s) begin
            ras_mem_q[ras_wa_s] <= pc_plus1_s;
        end else begin
            ras_mem_q[ras_wa_s] <= ras_mem_q[ras_wa_s];
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_plus1_s;
    assign bus.epc       = epc_q;
    assign bus.exl       = exl_q;
    assign bus.ras_empty = ras_empty_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: linear sequence of steps with hand-computed expectations.
module tb_pc_unit;
    localparam int AW = 32;
    localparam int PW = AW - 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_unit_if #(.AW(AW)) bus ();

    pc_unit #(
        .AW        (AW),
        .RESET_VEC (32'h0000_3000),
        .EXC_VEC   (32'h0000_4180),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_wr       = 1'b0;
        bus.npc_sel     = 2'b00;
        bus.call        = 1'b0;
        bus.ret_pred    = 1'b0;
        bus.redirect    = 1'b0;
        bus.exc_req     = 1'b0;
        bus.eret        = 1'b0;
    endtask

    task automatic jal(input logic [PW-1:0] tgt);
        idle();
        bus.pc_wr    = 1'b1;
        bus.call     = 1'b1;
        bus.npc_sel  = 2'b10;
        bus.j_target = tgt;
        step();
    endtask

    task automatic jr_ra();
        idle();
        bus.pc_wr    = 1'b1;
        bus.npc_sel  = 2'b11;
        bus.ret_pred = 1'b1;
        step();
    endtask

    task automatic redir(input logic [PW-1:0] tgt);
        idle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        bus.br_target   = 30'h0;
        bus.j_target    = 30'h0;
        bus.jr_target   = 30'h0;
        bus.redirect_pc = 30'h0;
        bus.exc_epc     = 30'h0;
        step();
        step();

        // reset state
        chk("rst_pc", bus.pc, 30'h0C00);
        chk("rst_epc", bus.epc, 30'h0);
        chk("rst_exl", {29'h0, bus.exl}, 30'h0);
        chk("rst_ras_empty", {29'h0, bus.ras_empty}, 30'h1);
        rst = 1'b1;

        // sequential fetch
        bus.pc_wr = 1'b1;
        step(); chk("seq1", bus.pc, 30'h0C01);
        step(); chk("seq2", bus.pc, 30'h0C02);
        step(); chk("seq3", bus.pc, 30'h0C03);
        chk("seq_plus1", bus.pc_plus1, 30'h0C04);

        // stall ignores branch; redirect overrides stall
        bus.pc_wr     = 1'b0;
        bus.npc_sel   = 2'b01;
        bus.br_target = 30'h1234;
        step(); chk("stall_hold", bus.pc, 30'h0C03);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 30'h2000;
        step(); chk("stall_redirect", bus.pc, 30'h2000);

        // pc+1 wrap at all-ones
        redir(30'h3FFF_FFFF);
        chk("wrap_plus1", bus.pc_plus1, 30'h0);
        idle(); bus.pc_wr = 1'b1;
        step(); chk("wrap_seq", bus.pc, 30'h0);

        // jal / jr $ra
        redir(30'h0C10);
        jal(30'h0D00);
        chk("jal_pc", bus.pc, 30'h0D00);
        chk("jal_nonempty", {29'h0, bus.ras_empty}, 30'h0);
        bus.jr_target = 30'h0;
        jr_ra();
        chk("ret_pc", bus.pc, 30'h0C11);
        chk("ret_empty", {29'h0, bus.ras_empty}, 30'h1);

        // five pushes into a 4-deep RAS, then pops
        redir(30'h0100);
        jal(30'h0200);
        jal(30'h0300);
        jal(30'h0400);
        jal(30'h0500);
        jal(30'h0600);
        bus.jr_target = 30'h3FF0;
        jr_ra(); chk("pop_a5", bus.pc, 30'h0501);
        jr_ra(); chk("pop_a4", bus.pc, 30'h0401);
        jr_ra(); chk("pop_a3", bus.pc, 30'h0301);
        chk("pop3_nonempty", {29'h0, bus.ras_empty}, 30'h0);
        jr_ra(); chk("pop_a2", bus.pc, 30'h0201);
        chk("pop4_empty", {29'h0, bus.ras_empty}, 30'h1);
        jr_ra(); chk("pop_fallback", bus.pc, 30'h3FF0);

        // push and pop in the same cycle replace the top
        jal(30'h0500);
        idle();
        bus.pc_wr     = 1'b1;
        bus.call      = 1'b1;
        bus.npc_sel   = 2'b11;
        bus.ret_pred  = 1'b1;
        bus.jr_target = 30'h0;
        step();
        chk("pushpop_pc", bus.pc, 30'h3FF1);
        chk("pushpop_nonempty", {29'h0, bus.ras_empty}, 30'h0);
        jr_ra();
        chk("pushpop_ret", bus.pc, 30'h0501);
        chk("pushpop_empty", {29'h0, bus.ras_empty}, 30'h1);

        // exception entry, nested request dropped, eret
        idle();
        bus.exc_req = 1'b1;
        bus.exc_epc = 30'h0C20;
        step();
        chk("exc_pc", bus.pc, 30'h1060);
        chk("exc_exl", {29'h0, bus.exl}, 30'h1);
        chk("exc_epc", bus.epc, 30'h0C20);
        bus.exc_epc = 30'h0999;
        step();
        chk("exc2_pc", bus.pc, 30'h1060);
        chk("exc2_epc", bus.epc, 30'h0C20);
        idle();
        bus.eret = 1'b1;
        step();
        chk("eret_pc", bus.pc, 30'h0C20);
        chk("eret_exl", {29'h0, bus.exl}, 30'h0);

        // eret with exl=0 falls through to normal advance
        bus.pc_wr = 1'b1;
        step();
        chk("eret_ignored", bus.pc, 30'h0C21);

        // exception beats eret and redirect
        idle();
        bus.exc_req     = 1'b1;
        bus.exc_epc     = 30'h0C30;
        bus.eret        = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 30'h0777;
        step();
        chk("prio_pc", bus.pc, 30'h1060);
        chk("prio_epc", bus.epc, 30'h0C30);
        chk("prio_exl", {29'h0, bus.exl}, 30'h1);

        // asynchronous reset mid-stall
        idle();
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 30'h0C00);
        chk("arst_exl", {29'h0, bus.exl}, 30'h0);
        chk("arst_epc", bus.epc, 30'h0);
        #1 rst = 1'b1;
        step();
        chk("arst_hold", bus.pc, 30'h0C00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
